m68k_bus_slave_ram: RTL and testbench
=====================================

// Module: m68k_bus_slave_ram
// PURPOSE
//  Motorola 68000-bus target downstream of the Wishbone-to-68000 bridge: decodes an
//  address window, serves word/byte reads and writes from internal RAM and answers
//  with open-drain _DTACK after programmable wait states. Optional bus monitor raises
//  _BERR on accesses nobody acknowledges. Serves as Zorro/chip-RAM model and bridge bench target.
// PARAMETERS
//  BASE_ADDR    24'h200000  byte base of window; aligned to 2^(ADDR_BITS+1)
//  ADDR_BITS    12          word-address bits of RAM (4096 x 16 = 8 KiB)
//  WAIT_STATES  2           extra CLK edges between decode and _DTACK assertion (0..15)
//  BERR_TIMEOUT 64          CLK edges of unacknowledged _AS before _BERR (M68K_SLAVE_BERR_EN only)
// PORTS
//  CLK     in     1   bus clock, all state on rising edge
//  _RST    in     1   asynchronous active-low reset
//  _AS     in     1   address strobe, active low
//  A       in     23  A[23:1] word address
//  R_W     in     1   1 = read, 0 = write
//  _UDS    in     1   upper byte strobe (D[15:8]), active low
//  _LDS    in     1   lower byte strobe (D[7:0]), active low
//  D       inout  16  data bus; driven only during a read acknowledge
//  _DTACK  inout  1   open-drain; driven 0 in ACK, else Z; wire value read back
//  _BERR   inout  1   open-drain bus error; Z unless monitor fires
// BEHAVIOUR
//  - Reset (_RST low, async): state IDLE, _DTACK=Z, _BERR=Z, D=Z, counters 0; RAM kept.
//  - hit = (A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]).
//  - FSM IDLE -> WAIT -> ACK -> IDLE:
//    IDLE: on edge with _AS=0 and hit, latch A[ADDR_BITS:1], R_W, _UDS, _LDS, load
//      wait counter = WAIT_STATES; go ACK if WAIT_STATES==0 else WAIT.
//    WAIT: decrement per edge; at 1 go ACK. _AS sampled 1 -> IDLE, no RAM write (abort).
//    ACK entry edge: write -> RAM[addr] updated per latched strobes (_UDS low -> [15:8],
//      _LDS low -> [7:0]; both high -> no write, still acked). Read -> D = RAM[addr].
//    ACK: _DTACK driven 0, read data held stable on D; stays until _AS sampled 1, then
//      IDLE, _DTACK and D released on that same edge.
//  - Latency: _DTACK low WAIT_STATES+1 edges after the edge first sampling _AS low.
//  - Back-to-back: bridge splits 32-bit access with _AS high one CLK; that one high edge
//    suffices to return to IDLE; next low edge starts a new access (no lost cycle).
//  - Strobes, R_W, A changing after decode are ignored (latched values used).
//  - Miss (not hit): no response, D and _DTACK stay Z.
//  - D never driven while R_W=0 or outside ACK; no contention with bridge write drive.
// CONFIGURATION
//  M68K_SLAVE_BERR_EN defined: monitor counts edges with _AS=0 and _DTACK wire=1 (any
//    target); counter clears when _AS=1 or _DTACK=0; at BERR_TIMEOUT drive _BERR=0 until
//    _AS sampled 1. Counter saturates, no wrap.
//  Not defined: no monitor logic, _BERR permanently Z.
// TESTING (BASE_ADDR=24'h200000, ADDR_BITS=12, WAIT_STATES=2, pull-ups on _DTACK/_BERR)
//  1 write 16'hBEEF @ 24'h200010, both strobes -> _DTACK low 3 edges after _AS low; read
//    back -> D=16'hBEEF while _DTACK low.
//  2 write 8'h12 on D[15:8] with _UDS only to same address -> read returns 16'h12EF.
//  3 32-bit bridge access @ 24'h200020, data 32'hCAFE_F00D -> two acks, words 16'hF00D
//    @ 24'h200022 and 16'hCAFE @ 24'h200020, bridge ACK_O returns 32'hCAFEF00D on read.
//  4 access @ 24'h300000 -> _DTACK and D stay Z; with M68K_SLAVE_BERR_EN _BERR low on
//    64th edge, released after _AS high; without macro _BERR stays Z.
//  5 _AS raised during WAIT of write 16'h5555 @ 24'h200040 -> no _DTACK, RAM unchanged.
//  6 _RST pulsed low while in ACK of read -> _DTACK and D release asynchronously, FSM
//    IDLE; later read of 24'h200010 still 16'h12EF.

Source files
------------

// File: rtl/m68k_bus_slave_ram.sv
`timescale 1ns/1ps
// m68k_bus_slave_ram
// Motorola 68000-bus RAM target sitting behind the Wishbone-to-68000 bridge.
// Decodes a fixed address window and serves word and byte reads and writes
// from internal RAM. It answers with an open-drain _DTACK after WAIT_STATES
// extra clock edges.
// Optional feature: define M68K_SLAVE_BERR_EN to add a bus monitor. The
// monitor drives _BERR low when _AS stays low for BERR_TIMEOUT edges without
// any target acknowledging.
module m68k_bus_slave_ram #(
    parameter logic [23:0] BASE_ADDR    = 24'h200000,
    parameter int          ADDR_BITS    = 12,
    parameter int          WAIT_STATES  = 2,
    parameter int          BERR_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        _RST,
    input  logic        _AS,
    input  logic [23:1] A,
    input  logic        R_W,
    input  logic        _UDS,
    input  logic        _LDS,
    inout  wire  [15:0] D,
    inout  wire         _DTACK,
    inout  wire         _BERR
);

    localparam int RAM_WORDS = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             wait_cnt;
    logic [3:0]             next_cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   rw_q;
    logic                   uds_q;
    logic                   lds_q;
    logic [ADDR_BITS-1:0]   cur_addr;
    logic                   cur_rw;
    logic                   cur_uds;
    logic                   cur_lds;
    logic                   hit;
    logic                   decode;
    logic                   ack_entry;
    logic [15:0]            rdata;
    logic [15:0]            ram [RAM_WORDS];

    assign hit    = (A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
    assign decode = (state == S_IDLE) && !_AS && hit;

    // With zero wait states the ACK entry edge is the decode edge itself.
    // The RAM port must then use the live bus values instead of the latched copies.
    assign cur_addr = decode ? A[ADDR_BITS:1] : addr_q;
    assign cur_rw   = decode ? R_W  : rw_q;
    assign cur_uds  = decode ? _UDS : uds_q;
    assign cur_lds  = decode ? _LDS : lds_q;

    // The RAM is only touched on the edge that enters ACK, and never while reset is held.
    assign ack_entry = _RST && (next_state == S_ACK) && (state != S_ACK);

    // State register, wait counter and the access attributes latched at decode
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            uds_q    <= 1'b1;
            lds_q    <= 1'b1;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            if (decode) begin
                addr_q <= A[ADDR_BITS:1];
                rw_q   <= R_W;
                uds_q  <= _UDS;
                lds_q  <= _LDS;
            end
        end
    end

    // Next-state logic: decode, count down wait states, then hold ACK until _AS rises
    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        case (state)
            S_IDLE: begin
                if (!_AS && hit) begin
                    next_cnt   = 4'(WAIT_STATES);
                    next_state = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (_AS) begin
                    next_state = S_IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        next_state = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (_AS) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // RAM port: a write updates the selected byte lanes; a read captures the word held on D during ACK
    always_ff @(posedge CLK) begin
        if (ack_entry) begin
            if (!cur_rw) begin
                if (!cur_uds) begin
                    ram[cur_addr][15:8] <= D[15:8];
                end
                if (!cur_lds) begin
                    ram[cur_addr][7:0] <= D[7:0];
                end
            end else begin
                rdata <= ram[cur_addr];
            end
        end
    end

    // Open-drain acknowledge. Data is driven only for reads in ACK, so it never fights the bridge.
    assign _DTACK = (state == S_ACK) ? 1'b0 : 1'bz;
    assign D      = ((state == S_ACK) && rw_q) ? rdata : 16'hzzzz;

`ifdef M68K_SLAVE_BERR_EN
    localparam int BERR_W = $clog2(BERR_TIMEOUT + 1);

    logic [BERR_W-1:0] berr_cnt;
    logic              berr_q;

    // Bus monitor: counts unacknowledged _AS-low edges on the wire (any target) and saturates.
    // It holds _BERR until _AS is seen high.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            berr_cnt <= '0;
            berr_q   <= 1'b0;
        end else if (_AS) begin
            berr_cnt <= '0;
            berr_q   <= 1'b0;
        end else begin
            if (!_DTACK) begin
                berr_cnt <= '0;
            end else if (berr_cnt != BERR_W'(BERR_TIMEOUT)) begin
                berr_cnt <= berr_cnt + BERR_W'(1);
            end
            if (_DTACK && (berr_cnt == BERR_W'(BERR_TIMEOUT - 1))) begin
                berr_q <= 1'b1;
            end
        end
    end

    assign _BERR = berr_q ? 1'b0 : 1'bz;
`else
    assign _BERR = 1'bz;
`endif

endmodule

// File: tb/tb_m68k_bus_slave_ram.sv
`timescale 1ns/1ps
// tb_m68k_bus_slave_ram
// Self-checking bench for the 68000-bus RAM target. It plays the bus master.
// A vector table covers the directed cases. Hand-written sequences cover
// back-to-back accesses, abort, bus error and reset inside ACK. A random phase
// is checked against a simple byte-address memory model.
// Honours M68K_SLAVE_BERR_EN to decide whether _BERR is expected.
module tb_m68k_bus_slave_ram;

    localparam logic [23:0] BASE  = 24'h200000;
    localparam int          ABITS = 12;
    localparam int          WS    = 2;
    localparam int          BTO   = 64;

    typedef struct {
        logic [23:0] a;
        logic        rd;
        logic        u;
        logic        l;
        logic [15:0] wd;
        logic        expAck;
        logic [15:0] expRd;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        asN;
    logic [23:1] addr;
    logic        rw;
    logic        udsN;
    logic        ldsN;
    logic [15:0] tbDout;
    logic        tbDoe;
    wire  [15:0] dBus;
    wire         dtackN;
    wire         berrN;

    int          vecCount;
    int          missCount;
    vec_t        vecs[$];
    logic [15:0] model [int];

    assign dBus = tbDoe ? tbDout : 16'hzzzz;
    pullup puD (dBus);
    pullup puDtack (dtackN);
    pullup puBerr (berrN);

    m68k_bus_slave_ram #(
        .BASE_ADDR   (BASE),
        .ADDR_BITS   (ABITS),
        .WAIT_STATES (WS),
        .BERR_TIMEOUT(BTO)
    ) dut (
        .CLK   (clk),
        ._RST  (rstN),
        ._AS   (asN),
        .A     (addr),
        .R_W   (rw),
        ._UDS  (udsN),
        ._LDS  (ldsN),
        .D     (dBus),
        ._DTACK(dtackN),
        ._BERR (berrN)
    );

    // free-running bus clock
    always #5 clk = ~clk;

    // hard time limit so the bench can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vecCount, missCount);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit inWindow(input logic [23:0] a);
        return (a >= BASE) && (a < BASE + 24'(2 * (1 << ABITS)));
    endfunction

    function automatic logic [15:0] modelRead(input logic [23:0] a);
        return model.exists(int'(a)) ? model[int'(a)] : 16'h0000;
    endfunction

    function automatic void modelWrite(input logic [23:0] a, input logic u, input logic l, input logic [15:0] wd);
        logic [15:0] w;
        w = modelRead(a);
        if (!u) w[15:8] = wd[15:8];
        if (!l) w[7:0]  = wd[7:0];
        model[int'(a)] = w;
    endfunction

    function automatic void addVec(input logic [23:0] a, input logic rd, input logic u, input logic l,
                                   input logic [15:0] wd, input logic expAck, input logic [15:0] expRd,
                                   input string name);
        vec_t v;
        v.a = a; v.rd = rd; v.u = u; v.l = l; v.wd = wd;
        v.expAck = expAck; v.expRd = expRd; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One complete bus cycle: drop _AS on a falling edge and wait (bounded) for _DTACK.
    // Then raise _AS on the next falling edge and return #1 after the following rising edge.
    task automatic applyStimulus(input logic [23:0] a, input logic r, input logic u, input logic l,
                                 input logic [15:0] wd, input int maxEdges,
                                 output logic acked, output int edges,
                                 output logic [15:0] rdAck, output logic [15:0] rdHold,
                                 output logic quiet);
        @(negedge clk);
        addr   = a[23:1];
        rw     = r;
        udsN   = u;
        ldsN   = l;
        tbDout = wd;
        tbDoe  = !r;
        asN    = 1'b0;
        acked  = 1'b0;
        edges  = 0;
        rdAck  = 16'h0000;
        rdHold = 16'h0000;
        quiet  = 1'b1;
        while (!acked && edges < maxEdges) begin
            @(posedge clk);
            #1;
            edges++;
            if (dtackN == 1'b0) acked = 1'b1;
            else if (r && dBus !== 16'hFFFF) quiet = 1'b0;
        end
        if (acked) rdAck = dBus;
        @(negedge clk);
        if (acked) rdHold = dBus;
        asN   = 1'b1;
        udsN  = 1'b1;
        ldsN  = 1'b1;
        tbDoe = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Full access with the standard checks: ack, latency, read data and bus release
    task automatic doAccess(input string name, input logic [23:0] a, input logic r, input logic u,
                            input logic l, input logic [15:0] wd, input logic expAck,
                            input logic [15:0] expRd);
        logic        acked;
        int          edges;
        logic [15:0] rdAck;
        logic [15:0] rdHold;
        logic        quiet;
        applyStimulus(a, r, u, l, wd, expAck ? 20 : 12, acked, edges, rdAck, rdHold, quiet);
        checkOutput({name, "_ack"}, 32'(acked), 32'(expAck));
        if (expAck) begin
            checkOutput({name, "_latency"}, 32'(edges), 32'(WS + 1));
            if (r) begin
                checkOutput({name, "_data"}, 32'(rdAck), 32'(expRd));
                checkOutput({name, "_hold"}, 32'(rdHold), 32'(expRd));
            end
        end else begin
            checkOutput({name, "_quiet"}, 32'(quiet), 32'd1);
        end
        checkOutput({name, "_release"}, {15'd0, dtackN, dBus}, {15'd0, 1'b1, 16'hFFFF});
        if (expAck && acked && !r) modelWrite(a, u, l, wd);
    endtask

    // Main test sequence
    initial begin
        logic [23:0] a;
        logic        r;
        logic        u;
        logic        l;
        logic [15:0] wd;
        logic        acked;
        logic        quiet;
        int          berrEdge;
        int          expBerr;
        int          edges;
        logic [15:0] rdAck;
        logic [15:0] rdHold;
        logic [15:0] hiWord;
        logic [15:0] loWord;

        vecCount  = 0;
        missCount = 0;
        rstN   = 1'b0;
        asN    = 1'b1;
        addr   = '0;
        rw     = 1'b1;
        udsN   = 1'b1;
        ldsN   = 1'b1;
        tbDout = 16'h0000;
        tbDoe  = 1'b0;

        addVec(24'h200010, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b1, 16'h0000, "wr_beef");
        addVec(24'h200010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, "rd_beef");
        addVec(24'h200010, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h0000, "wr_uds_only");
        addVec(24'h200010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h12EF, "rd_12ef");
        addVec(24'h200010, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, "wr_no_strobe");
        addVec(24'h200010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h12EF, "rd_after_no_strobe");
        addVec(24'h200012, 1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b1, 16'h0000, "wr_a5a5");
        addVec(24'h200012, 1'b0, 1'b1, 1'b0, 16'hFF3C, 1'b1, 16'h0000, "wr_lds_only");
        addVec(24'h200012, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hA53C, "rd_a53c");
        addVec(24'h201FFE, 1'b0, 1'b0, 1'b0, 16'h7E57, 1'b1, 16'h0000, "wr_top");
        addVec(24'h201FFE, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7E57, "rd_top");
        addVec(24'h200000, 1'b0, 1'b0, 1'b0, 16'h0123, 1'b1, 16'h0000, "wr_bottom");
        addVec(24'h202000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, "miss_above");
        addVec(24'h1FFFFE, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, "miss_below");
        addVec(24'h202000, 1'b0, 1'b0, 1'b0, 16'hDEAD, 1'b0, 16'h0000, "miss_wr_above");
        addVec(24'h300000, 1'b0, 1'b0, 1'b0, 16'hD00D, 1'b0, 16'h0000, "miss_wr_far");
        addVec(24'h200000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0123, "rd_bottom_no_alias");

        #12;
        checkOutput("reset_dtack", 32'(dtackN), 32'd1);
        checkOutput("reset_d", 32'(dBus), 32'hFFFF);
        checkOutput("reset_berr", 32'(berrN), 32'd1);
        @(negedge clk);
        rstN = 1'b1;

        foreach (vecs[i]) begin
            doAccess(vecs[i].name, vecs[i].a, vecs[i].rd, vecs[i].u, vecs[i].l,
                     vecs[i].wd, vecs[i].expAck, vecs[i].expRd);
        end

        $display("[TB] back-to-back 32-bit access");
        doAccess("b2b_wr_hi", 24'h200020, 1'b0, 1'b0, 1'b0, 16'hCAFE, 1'b1, 16'h0000);
        doAccess("b2b_wr_lo", 24'h200022, 1'b0, 1'b0, 1'b0, 16'hF00D, 1'b1, 16'h0000);
        applyStimulus(24'h200020, 1'b1, 1'b0, 1'b0, 16'h0000, 20, acked, edges, hiWord, rdHold, quiet);
        checkOutput("b2b_rd_hi_latency", 32'(edges), 32'(WS + 1));
        applyStimulus(24'h200022, 1'b1, 1'b0, 1'b0, 16'h0000, 20, acked, edges, loWord, rdHold, quiet);
        checkOutput("b2b_rd_lo_latency", 32'(edges), 32'(WS + 1));
        checkOutput("b2b_long", {hiWord, loWord}, 32'hCAFEF00D);

        $display("[TB] unacknowledged access and bus monitor");
        @(negedge clk);
        addr = 23'h180000;
        rw   = 1'b1;
        udsN = 1'b0;
        ldsN = 1'b0;
        asN  = 1'b0;
        berrEdge = 0;
        quiet    = 1'b1;
        for (int e = 1; e <= 80 && berrEdge == 0; e++) begin
            @(posedge clk);
            #1;
            if (dtackN !== 1'b1 || dBus !== 16'hFFFF) quiet = 1'b0;
            if (berrN == 1'b0) berrEdge = e;
        end
`ifdef M68K_SLAVE_BERR_EN
        expBerr = BTO;
`else
        expBerr = 0;
`endif
        checkOutput("miss_quiet_bus", 32'(quiet), 32'd1);
        checkOutput("berr_edge", 32'(berrEdge), 32'(expBerr));
        @(negedge clk);
        asN  = 1'b1;
        udsN = 1'b1;
        ldsN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("berr_release", 32'(berrN), 32'd1);

        $display("[TB] abort during wait states");
        doAccess("abort_pre_wr", 24'h200040, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b1, 16'h0000);
        @(negedge clk);
        addr   = 23'h100020;
        rw     = 1'b0;
        udsN   = 1'b0;
        ldsN   = 1'b0;
        tbDout = 16'h5555;
        tbDoe  = 1'b1;
        asN    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        asN   = 1'b1;
        udsN  = 1'b1;
        ldsN  = 1'b1;
        tbDoe = 1'b0;
        quiet = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            if (dtackN !== 1'b1) quiet = 1'b0;
        end
        checkOutput("abort_no_dtack", 32'(quiet), 32'd1);
        doAccess("abort_rd", 24'h200040, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, modelRead(24'h200040));

        $display("[TB] reset inside ACK of a read");
        @(negedge clk);
        addr = 23'h100008;
        rw   = 1'b1;
        udsN = 1'b0;
        ldsN = 1'b0;
        asN  = 1'b0;
        acked = 1'b0;
        for (int e = 0; e < 20 && !acked; e++) begin
            @(posedge clk);
            #1;
            if (dtackN == 1'b0) acked = 1'b1;
        end
        checkOutput("rst_pre_ack", 32'(acked), 32'd1);
        checkOutput("rst_pre_data", 32'(dBus), 32'(modelRead(24'h200010)));
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("rst_async_release", {15'd0, dtackN, dBus}, {15'd0, 1'b1, 16'hFFFF});
        @(negedge clk);
        asN  = 1'b1;
        udsN = 1'b1;
        ldsN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        doAccess("rst_ram_kept", 24'h200010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h12EF);

        $display("[TB] randomized accesses against the memory model");
        for (int i = 0; i < 16; i++) begin
            a = 24'h200100 + 24'(2 * i);
            doAccess("rand_init", a, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b1, 16'h0000);
        end
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? 24'h202000 : 24'h1FF000;
                a = a + 24'(2 * $urandom_range(0, 2047));
            end else begin
                a = 24'h200100 + 24'(2 * $urandom_range(0, 15));
            end
            r  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            doAccess("rand", a, r, u, l, wd, inWindow(a), modelRead(a));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
